// File: rtl/clk_div_bank.sv
// Runtime-reprogrammable bank of divided clocks with per-channel phase offset.
// Shadow configs are committed atomically by an apply, which restarts all channels and the lock window.
module clk_div_bank #(
    parameter int NUM_CLOCKS  = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1,
    localparam int LOCK_W     = $clog2(LOCK_CYCLES + 1)
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_chan,
    input  logic [CNT_W-1:0]      cfg_div,
    input  logic [CNT_W-1:0]      cfg_phase,
    input  logic                  cfg_apply,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic                  locked
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t              DIV_RST  = cnt_t'(DEFAULT_DIV);
    localparam cnt_t              MIN_DIV  = cnt_t'(2);
    localparam cnt_t              ONE      = cnt_t'(1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

    cnt_t [NUM_CLOCKS-1:0] shadow_div_q, shadow_div_d;
    cnt_t [NUM_CLOCKS-1:0] shadow_phase_q, shadow_phase_d;
    cnt_t [NUM_CLOCKS-1:0] active_div_q, active_div_d;
    cnt_t [NUM_CLOCKS-1:0] active_phase_q, active_phase_d;
    cnt_t [NUM_CLOCKS-1:0] cnt_q, cnt_d;

    logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
    logic [NUM_CLOCKS-1:0] en_q, en_d;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic                  locked_q, locked_d;
    logic                  restart_q, restart_d;

    logic wr_en;
    logic apply_en;
    logic chan_ok;
    cnt_t wr_div;
    cnt_t wr_phase;

    // Handshake: cfg_valid and cfg_apply take effect only on an edge where
    // cfg_ready (== locked) is high; otherwise they are dropped, not queued.
    assign wr_en    = cfg_valid & locked_q;
    assign apply_en = cfg_apply & locked_q;
    assign chan_ok  = (int'(cfg_chan) < NUM_CLOCKS);

    // Write path: clamp, update one shadow, then copy shadows so a same-edge
    // write is part of the apply.
    always_comb begin
        wr_div         = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
        wr_phase       = (cfg_phase > (wr_div - ONE)) ? (wr_div - ONE) : cfg_phase;
        shadow_div_d   = shadow_div_q;
        shadow_phase_d = shadow_phase_q;
        active_div_d   = active_div_q;
        active_phase_d = active_phase_q;
        restart_d      = 1'b0;
        if (wr_en && chan_ok) begin
            shadow_div_d[cfg_chan]   = wr_div;
            shadow_phase_d[cfg_chan] = wr_phase;
        end
        if (apply_en) begin
            active_div_d   = shadow_div_d;
            active_phase_d = shadow_phase_d;
            restart_d      = 1'b1;
        end
    end

    // Channel counters; outputs are decoded from the value entering the counter.
    always_comb begin
        cnt_d    = cnt_q;
        outclk_d = '0;
        en_d     = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (restart_q) begin
                cnt_d[i] = (active_phase_q[i] == '0) ? '0
                                                     : (active_div_q[i] - active_phase_q[i]);
            end else if (cnt_q[i] == (active_div_q[i] - ONE)) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
            outclk_d[i] = (cnt_d[i] < (active_div_q[i] >> 1));
            en_d[i]     = (cnt_d[i] == '0);
        end
    end

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (restart_q) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q < LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
        locked_d = (lock_cnt_d == LOCK_MAX);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            shadow_div_q   <= {NUM_CLOCKS{DIV_RST}};
            shadow_phase_q <= '0;
            active_div_q   <= {NUM_CLOCKS{DIV_RST}};
            active_phase_q <= '0;
            cnt_q          <= '0;
            outclk_q       <= '0;
            en_q           <= '0;
            lock_cnt_q     <= '0;
            locked_q       <= 1'b0;
            restart_q      <= 1'b1;
        end else begin
            shadow_div_q   <= shadow_div_d;
            shadow_phase_q <= shadow_phase_d;
            active_div_q   <= active_div_d;
            active_phase_q <= active_phase_d;
            cnt_q          <= cnt_d;
            outclk_q       <= outclk_d;
            en_q           <= en_d;
            lock_cnt_q     <= lock_cnt_d;
            locked_q       <= locked_d;
            restart_q      <= restart_d;
        end
    end

    assign outclk    = outclk_q;
    assign outclk_en = en_q;
    assign locked    = locked_q;
    assign cfg_ready = locked_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed plan plus random config traffic, scored per edge
// against a closed-form model (counter = (start + edges since restart) mod D).
module tb_clk_div_bank;

    localparam int N     = 3;
    localparam int CNT_W = 8;
    localparam int DEF_D = 4;
    localparam int LOCK  = 16;
    localparam int CH_W  = 2;
    localparam int W     = 2 * N + 2;

    logic             refclk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_phase;
    logic             cfg_apply;
    logic [N-1:0]     outclk;
    logic [N-1:0]     outclk_en;
    logic             locked;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // reference model state
    int sh_d[N];
    int sh_p[N];
    int ac_d[N];
    int ac_p[N];
    int edge_n;
    int m_r;
    bit m_restart;
    bit m_locked;

    clk_div_bank #(
        .NUM_CLOCKS (N),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEF_D),
        .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_apply(cfg_apply),
        .outclk   (outclk),
        .outclk_en(outclk_en),
        .locked   (locked)
    );

    // clock
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            sh_d[i] = DEF_D;
            sh_p[i] = 0;
            ac_d[i] = DEF_D;
            ac_p[i] = 0;
        end
        edge_n    = 0;
        m_r       = 0;
        m_restart = 1'b1;
        m_locked  = 1'b0;
    endfunction

    // Predicts the outputs of the coming edge, then applies that edge's accepted requests.
    function automatic void model_step();
        logic [N-1:0] oc;
        logic [N-1:0] en;
        logic lk;
        logic acc;
        int s;
        int c;
        int d;
        int p;
        int ch;
        edge_n++;
        acc = m_locked;
        if (m_restart) begin
            m_r       = edge_n;
            m_restart = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            s     = (ac_p[i] == 0) ? 0 : ac_d[i] - ac_p[i];
            c     = (s + (edge_n - m_r)) % ac_d[i];
            oc[i] = (c < ac_d[i] / 2);
            en[i] = (c == 0);
        end
        lk = ((edge_n - m_r) >= LOCK);
        exp_q.push_back({lk, lk, en, oc});
        m_locked = lk;
        ch = int'(cfg_chan);
        if (acc && cfg_valid && ch < N) begin
            d = int'(cfg_div);
            if (d < 2) d = 2;
            p = int'(cfg_phase);
            if (p > d - 1) p = d - 1;
            sh_d[ch] = d;
            sh_p[ch] = p;
        end
        if (acc && cfg_apply) begin
            ac_d      = sh_d;
            ac_p      = sh_p;
            m_restart = 1'b1;
        end
    endfunction

    // driver tasks
    task automatic cycle(input logic v, input int ch, input int d, input int p, input logic ap);
        @(negedge refclk);
        cfg_valid = v;
        cfg_chan  = CH_W'(ch);
        cfg_div   = CNT_W'(d);
        cfg_phase = CNT_W'(p);
        cfg_apply = ap;
        model_step();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge refclk);
        cfg_valid = 1'b0;
        cfg_apply = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({cfg_ready, locked, outclk_en, outclk} !== '0) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", {cfg_ready, locked, outclk_en, outclk}, {W{1'b0}});
        end
        repeat (2) @(posedge refclk);
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    // scoreboard monitor: one expected entry per edge out of reset
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(posedge refclk);
            #1;
            if (!rst) begin
                act_v = {cfg_ready, locked, outclk_en, outclk};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL edge_underflow got %b exp <none> t=%0t", act_v, $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act_v !== exp_v) begin
                        errors++;
                        $display("FAIL edge_outputs {rdy,lk,en,clk} got %b exp %b t=%0t", act_v, exp_v, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        cfg_apply = 1'b0;
        model_reset();
        #1 rst = 1'b1;

        // defaults and lock window
        do_reset();
        idle(20);

        // ch0 D=6 P=0, ch1 D=5 P=2
        cycle(1'b1, 0, 6, 0, 1'b0);
        cycle(1'b1, 1, 5, 2, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1);
        idle(20);

        // clamps: D=0 P=9 -> D=2 P=1
        cycle(1'b1, 0, 0, 9, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1);
        idle(3);
        // requests while unlocked are dropped
        cycle(1'b1, 0, 8, 0, 1'b1);
        idle(20);
        cycle(1'b0, 0, 0, 0, 1'b1);
        idle(20);

        // same-edge write + apply, then out-of-range channel
        cycle(1'b1, 1, 3, 0, 1'b1);
        idle(20);
        cycle(1'b1, 3, 7, 1, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1);
        idle(20);

        // maximum divide, phase at D-1, D=1 clamp
        cycle(1'b1, 2, 255, 254, 1'b0);
        cycle(1'b1, 0, 1, 1, 1'b0);
        cycle(1'b1, 1, 7, 6, 1'b1);
        idle(40);

        // unapplied writes lost on mid-period reset
        cycle(1'b1, 0, 9, 3, 1'b0);
        cycle(1'b1, 1, 11, 0, 1'b0);
        idle(2);
        do_reset();
        idle(20);

        // random traffic
        for (int it = 0; it < 60; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) begin
                cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 14), $urandom_range(0, 15),
                      ($urandom_range(0, 5) == 0));
            end
            if ($urandom_range(0, 3) != 0) begin
                cycle(($urandom_range(0, 1) == 1), $urandom_range(0, 3), $urandom_range(0, 14),
                      $urandom_range(0, 15), 1'b1);
            end
            idle($urandom_range(1, 25));
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        idle(3);

        @(posedge refclk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got %0d entries exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Parametrised, runtime-reprogrammable multi-channel clock generator built in fabric logic. It derives NUM_CLOCKS divided clocks, each with a per-channel divide ratio and phase offset, from one reference clock. Each channel also produces a single-cycle enable pulse, and a lock indicator reports output stability after reset or reconfiguration. It sits beside the vendor PLL and serves slow or phase-staggered clocks that the PLL cannot provide or cannot retune at runtime.

Parameters:
NUM_CLOCKS, 2, number of output channels (1..16)
CNT_W, 16, width of the divide and phase fields and of each channel counter
DEFAULT_DIV, 4, divide ratio loaded into every channel at reset (2..2^CNT_W-1)
LOCK_CYCLES, 16, refclk edges from a restart until locked asserts (>=1)
Localparam CH_W = (NUM_CLOCKS>1) ? $clog2(NUM_CLOCKS) : 1

Ports:
refclk  in  1  reference clock; all logic is on its rising edge
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write/apply accepted; equals locked
cfg_chan  in  CH_W  channel selected by a write
cfg_div  in  CNT_W  divide ratio D (period in refclk cycles)
cfg_phase  in  CNT_W  phase delay P in refclk cycles
cfg_apply  in  1  single-cycle pulse; commits all shadow configs atomically
outclk  out  NUM_CLOCKS  divided clocks, one bit per channel
outclk_en  out  NUM_CLOCKS  one-cycle pulse per channel period (channel counter == 0)
locked  out  1  outputs stable under the current config

Behaviour:
- Reset (async, rst=1): outclk=0, outclk_en=0, locked=0. Active and shadow D=DEFAULT_DIV and P=0 for all channels. All counters 0. Restart pending.
- Edge numbering: edge 1 is the first refclk rising edge with rst=0.
- Restart edge r is edge 1 after reset, or edge a+1 after an apply accepted at edge a. At edge r:
  - each channel counter loads S=(P==0)?0:D-P using the active config;
  - locked clears (after an apply);
  - the lock counter loads 0.
- Running: at every non-restart edge, counter <= (counter==D-1) ? 0 : counter+1.
- All outputs are registered and reflect the counter value loaded or advanced at the same edge. There is no combinational path from any input to any output.
  - outclk[i] = 1 iff counter_i < (D_i>>1). Even D gives 50% duty; odd D is high for floor(D/2) cycles.
  - outclk_en[i] = 1 iff counter_i == 0.
  - First outclk_en after a restart occurs at edge r+P.
- Lock: the counter increments each edge after r, saturating at LOCK_CYCLES. locked=1 from edge r+LOCK_CYCLES onward until the next restart or reset.
- cfg_ready = locked.
- Write: cfg_valid & cfg_ready at an edge updates shadow[cfg_chan] only. Active config and outputs are unchanged.
  - Clamps at write: D<2 stores 2. P>D-1 stores D-1, using the clamped D.
  - cfg_chan >= NUM_CLOCKS: accepted, no effect.
- Apply: cfg_apply & cfg_ready at edge a copies all shadows to active. Edge a+1 is a restart.
  - A write in the same edge as an apply is included in that apply (write first, then copy).
  - cfg_apply or cfg_valid while locked=0 is ignored; nothing is stored and nothing is queued.
- Reset mid-operation: immediate return to reset state. Shadow writes not yet applied are lost.

Test Plan:
1. Defaults (NUM_CLOCKS=2, DEFAULT_DIV=4, LOCK_CYCLES=16): release reset -> edge 1: outclk=11, en=11. Edges 1,2 high; edges 3,4 low; period 4. en at edges 1,5,9. locked=0 through edge 16, 1 at edge 17.
2. Locked; write ch0 D=6 P=0 and ch1 D=5 P=2, then apply at edge a:
   - outputs unchanged through edge a.
   - ch0: en at a+1, outclk high a+1..a+3, low a+4..a+6.
   - ch1: counter 3 at a+1, en at a+3, high a+3..a+4, low a+5..a+7.
   - locked low a+1..a+16, high at a+17.
3. Clamps: write ch0 D=0 P=9, apply -> ch0 D=2, P=1; en first at a+2, then every 2 edges; outclk alternates.
4. Unlocked ignore: during the lock window, assert cfg_valid (ch0 D=8) and cfg_apply -> cfg_ready=0; no restart; a later apply while locked shows the old ch0 config retained.
5. Same-edge write+apply (ch1 D=3 P=0) -> ch1 runs D=3 from a+1 (high 1 of 3, en at a+1,a+4). Write to cfg_chan=3 -> no effect on any channel.
6. Assert rst mid-period and after unapplied shadow writes -> outputs/locked 0 immediately; after release, test 1 timing repeats exactly with DEFAULT_DIV on all channels.
